// File: rtl/student_ss_analog_seq_if.sv
// rtl/student_ss_analog_seq_if.sv - APB register bus bundle for the analog scan sequencer
interface student_ss_analog_seq_if #(
  parameter int APB_AW = 10,
  parameter int APB_DW = 32
);
  logic              PSEL;
  logic              PENABLE;
  logic              PWRITE;
  logic [APB_AW-1:0] PADDR;
  logic [APB_DW-1:0] PWDATA;
  logic [APB_DW-1:0] PRDATA;
  logic              PREADY;
  logic              PSLVERR;

  modport master (
    output PSEL, PENABLE, PWRITE, PADDR, PWDATA,
    input  PRDATA, PREADY, PSLVERR
  );

  modport slave (
    input  PSEL, PENABLE, PWRITE, PADDR, PWDATA,
    output PRDATA, PREADY, PSLVERR
  );
endinterface

// File: rtl/student_ss_analog_seq.sv
// rtl/student_ss_analog_seq.sv - APB analog channel scan sequencer; STUDENT_ANA_MAJ_EN selects 3-sample majority capture
module student_ss_analog_seq #(
  parameter int NUM_IO      = 2,
  parameter int APB_AW      = 10,
  parameter int APB_DW      = 32,
  parameter int SETTLE_W    = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic                   clk_in,
  input  logic                   reset_int,
  student_ss_analog_seq_if.slave apb,
  output logic                   irq_out,
  inout  wire  [NUM_IO-1:0]      ana_core_out,
  inout  wire  [NUM_IO-1:0]      ana_core_in
);
  localparam int CH_W = (NUM_IO > 1) ? $clog2(NUM_IO) : 1;
  localparam logic [CH_W-1:0] LAST_CH = CH_W'(NUM_IO - 1);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_DRIVE, S_SAMPLE, S_NEXT, S_DONE} state_t;

  state_t              state_q, state_d;
  logic [CH_W-1:0]     ch_q, ch_d;
  logic                cont, irq_en, done;
  logic [NUM_IO-1:0]   ch_en, result;
  logic [SETTLE_W-1:0] settle, settle_cnt;
  logic [NUM_IO-1:0]   sync_q [SYNC_STAGES];
  logic [NUM_IO-1:0]   synced;
  logic                samp_last, samp_bit, maj_flag;
  logic                acc, wr, unmapped, start_req, abort_req, done_set, busy;
  logic                sel_ctrl, sel_status, sel_chen, sel_settle, sel_result;
  logic [APB_DW-1:0]   rdata;
  wire                 unused_pwdata = ^apb.PWDATA;

  assign acc        = apb.PSEL & apb.PENABLE;
  assign wr         = acc & apb.PWRITE;
  assign sel_ctrl   = apb.PADDR == APB_AW'(8'h00);
  assign sel_status = apb.PADDR == APB_AW'(8'h04);
  assign sel_chen   = apb.PADDR == APB_AW'(8'h08);
  assign sel_settle = apb.PADDR == APB_AW'(8'h0C);
  assign sel_result = apb.PADDR == APB_AW'(8'h10);
  assign unmapped   = !(sel_ctrl | sel_status | sel_chen | sel_settle | sel_result);
  assign start_req  = wr & sel_ctrl & apb.PWDATA[0];
  assign abort_req  = wr & sel_ctrl & apb.PWDATA[3];
  assign busy       = state_q != S_IDLE;
  assign done_set   = (state_d == S_DONE) && (state_q != S_DONE);
  assign irq_out    = done & irq_en;
  assign synced     = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk_in or negedge reset_int) begin
    if (!reset_int) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
    end else begin
      sync_q[0] <= ana_core_in;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

`ifdef STUDENT_ANA_MAJ_EN
  logic [1:0] samp_cnt;
  logic [1:0] maj_q;
  assign maj_flag  = 1'b1;
  assign samp_last = samp_cnt == 2'd2;
  assign samp_bit  = (maj_q[0] & maj_q[1]) | (maj_q[0] & synced[ch_q]) | (maj_q[1] & synced[ch_q]);
  always_ff @(posedge clk_in or negedge reset_int) begin
    if (!reset_int) begin
      samp_cnt <= '0;
      maj_q    <= '0;
    end else if (state_q == S_SAMPLE && !samp_last) begin
      samp_cnt <= samp_cnt + 2'd1;
      maj_q    <= {maj_q[0], synced[ch_q]};
    end else begin
      samp_cnt <= '0;
    end
  end
`else
  assign maj_flag  = 1'b0;
  assign samp_last = 1'b1;
  assign samp_bit  = synced[ch_q];
`endif

  always_ff @(posedge clk_in or negedge reset_int) begin
    if (!reset_int) begin
      cont   <= 1'b0;
      irq_en <= 1'b0;
      ch_en  <= '0;
      settle <= SETTLE_W'(1);
      done   <= 1'b0;
    end else begin
      if (wr & sel_ctrl) begin
        cont   <= apb.PWDATA[1];
        irq_en <= apb.PWDATA[2];
      end
      if (wr & sel_chen)   ch_en  <= apb.PWDATA[NUM_IO-1:0];
      if (wr & sel_settle) settle <= apb.PWDATA[SETTLE_W-1:0];
      // a scan finishing in the same cycle as a w1c keeps done set
      if (done_set) done <= 1'b1;
      else if (wr & sel_status & apb.PWDATA[1]) done <= 1'b0;
    end
  end

  always_comb begin
    state_d = state_q;
    ch_d    = ch_q;
    unique case (state_q)
      S_IDLE:   if (start_req) state_d = S_LOAD;
      S_LOAD: begin
        ch_d    = '0;
        state_d = ch_en[0] ? S_DRIVE : S_NEXT;
      end
      S_DRIVE:  if (settle_cnt <= SETTLE_W'(1)) state_d = S_SAMPLE;
      S_SAMPLE: if (samp_last) state_d = S_NEXT;
      S_NEXT: begin
        if (ch_q == LAST_CH) begin
          state_d = S_DONE;
        end else begin
          ch_d    = ch_q + CH_W'(1);
          state_d = ch_en[ch_d] ? S_DRIVE : S_NEXT;
        end
      end
      S_DONE:   state_d = cont ? S_LOAD : S_IDLE;
      default:  state_d = S_IDLE;
    endcase
    if (abort_req) state_d = S_IDLE;
  end

  always_ff @(posedge clk_in or negedge reset_int) begin
    if (!reset_int) begin
      state_q    <= S_IDLE;
      ch_q       <= '0;
      settle_cnt <= '0;
      result     <= '0;
    end else begin
      state_q <= state_d;
      ch_q    <= ch_d;
      // settle time is latched on DRIVE entry so mid-scan writes apply to the next channel
      if (state_d == S_DRIVE && state_q != S_DRIVE)
        settle_cnt <= (settle == '0) ? SETTLE_W'(1) : settle;
      else if (state_q == S_DRIVE)
        settle_cnt <= settle_cnt - SETTLE_W'(1);
      if (state_q == S_LOAD) result <= '0;
      else if (state_q == S_SAMPLE && samp_last) result[ch_q] <= samp_bit;
    end
  end

  for (genvar i = 0; i < NUM_IO; i++) begin : g_pin
    assign ana_core_out[i] = (state_q == S_DRIVE && ch_q == CH_W'(i)) ? 1'b1 : 1'bz;
  end

  always_comb begin
    rdata = '0;
    if (sel_ctrl)        rdata[2:1]          = {irq_en, cont};
    else if (sel_status) rdata[2:0]          = {maj_flag, done, busy};
    else if (sel_chen)   rdata[NUM_IO-1:0]   = ch_en;
    else if (sel_settle) rdata[SETTLE_W-1:0] = settle;
    else if (sel_result) rdata[NUM_IO-1:0]   = result;
  end

  assign apb.PRDATA  = (acc & !apb.PWRITE) ? rdata : '0;
  assign apb.PREADY  = 1'b1;
  assign apb.PSLVERR = acc & unmapped;
endmodule

// File: tb/tb_student_ss_analog_seq.sv
// tb/tb_student_ss_analog_seq.sv - scoreboard bench for the analog scan sequencer
module tb_student_ss_analog_seq;
`ifdef STUDENT_ANA_MAJ_EN
  localparam int SAMP = 3;
  localparam logic [31:0] MAJF = 32'h4;
`else
  localparam int SAMP = 1;
  localparam logic [31:0] MAJF = 32'h0;
`endif

  logic clk_in = 1'b0;
  logic reset_int = 1'b0;
  logic irq_out;
  wire  [1:0] ana_core_out;
  wire  [1:0] ana_core_in;
  logic [1:0] in_drv = 2'b00;
  assign ana_core_in = in_drv;

  int checks = 0;
  int failures = 0;
  int hi_cnt [2];

  typedef struct {
    string       name;
    logic [31:0] data;
    logic        err;
  } exp_t;
  exp_t sbq[$];

  student_ss_analog_seq_if #(.APB_AW(10), .APB_DW(32)) apb ();

  student_ss_analog_seq dut (
    .clk_in      (clk_in),
    .reset_int   (reset_int),
    .apb         (apb),
    .irq_out     (irq_out),
    .ana_core_out(ana_core_out),
    .ana_core_in (ana_core_in)
  );

  always #5 clk_in = ~clk_in;

  function automatic logic [1:0] drv_mask();
    logic [1:0] m;
    for (int i = 0; i < 2; i++) m[i] = (ana_core_out[i] === 1'b1);
    return m;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  // read monitor: compares every APB access-phase read against the scoreboard head
  always @(negedge clk_in) begin
    if (apb.PSEL && apb.PENABLE && !apb.PWRITE) begin
      if (sbq.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_read actual=0x%0h expected=none", apb.PRDATA);
      end else begin
        exp_t e;
        e = sbq.pop_front();
        check({e.name, "_data"}, apb.PRDATA, e.data);
        check({e.name, "_slverr"}, {31'd0, apb.PSLVERR}, {31'd0, e.err});
      end
    end
    for (int i = 0; i < 2; i++) if (ana_core_out[i] === 1'b1) hi_cnt[i]++;
  end

  task automatic apb_write(input logic [9:0] addr, input logic [31:0] data);
    @(posedge clk_in); #1;
    apb.PSEL = 1'b1; apb.PENABLE = 1'b0; apb.PWRITE = 1'b1; apb.PADDR = addr; apb.PWDATA = data;
    @(posedge clk_in); #1;
    apb.PENABLE = 1'b1;
    @(posedge clk_in); #1;
    apb.PSEL = 1'b0; apb.PENABLE = 1'b0; apb.PWRITE = 1'b0;
  endtask

  task automatic apb_read(input logic [9:0] addr, input logic [31:0] exp, input logic err, input string name);
    exp_t e;
    e.name = name; e.data = exp; e.err = err;
    @(posedge clk_in); #1;
    apb.PSEL = 1'b1; apb.PENABLE = 1'b0; apb.PWRITE = 1'b0; apb.PADDR = addr;
    sbq.push_back(e);
    @(posedge clk_in); #1;
    apb.PENABLE = 1'b1;
    @(posedge clk_in); #1;
    apb.PSEL = 1'b0; apb.PENABLE = 1'b0;
  endtask

  function automatic int settle_eff(input int s);
    return (s == 0) ? 1 : s;
  endfunction

  // cycles from the committing start write until done is visible
  function automatic int scan_latency(input logic [1:0] en, input int s);
    int l = 1;
    for (int i = 0; i < 2; i++) l += en[i] ? (settle_eff(s) + 1 + SAMP) : 1;
    return l;
  endfunction

  task automatic wait_pin(input int idx, input string name);
    int n = 0;
    while (ana_core_out[idx] !== 1'b1 && n < 400) begin @(posedge clk_in); #1; n++; end
    check(name, {31'd0, ana_core_out[idx] === 1'b1}, 32'd1);
  endtask

  task automatic run_scan(input logic [1:0] en, input int s, input logic [1:0] in, input string name);
    int cyc = 0;
    apb_write(10'h08, {30'd0, en});
    apb_write(10'h0C, s);
    in_drv = in;
    apb_write(10'h04, 32'h2);
    check({name, "_irq_pre"}, {31'd0, irq_out}, 32'd0);
    hi_cnt[0] = 0; hi_cnt[1] = 0;
    apb_write(10'h00, 32'h5);
    while (irq_out !== 1'b1 && cyc < 500) begin @(posedge clk_in); #1; cyc++; end
    check({name, "_latency"}, cyc, scan_latency(en, s));
    for (int i = 0; i < 2; i++)
      check($sformatf("%s_drive_cycles_ch%0d", name, i), hi_cnt[i], en[i] ? settle_eff(s) : 0);
    apb_read(10'h10, {30'd0, en & in}, 1'b0, {name, "_result"});
    apb_read(10'h04, 32'h2 | MAJF, 1'b0, {name, "_status"});
    apb_write(10'h04, 32'h2);
    check({name, "_irq_cleared"}, {31'd0, irq_out}, 32'd0);
  endtask

  initial begin
    apb.PSEL = 1'b0; apb.PENABLE = 1'b0; apb.PWRITE = 1'b0; apb.PADDR = '0; apb.PWDATA = '0;
    repeat (3) @(posedge clk_in);
    #2;
    check("reset_pins", {30'd0, drv_mask()}, 32'd0);
    check("reset_irq", {31'd0, irq_out}, 32'd0);
    reset_int = 1'b1;
    apb_read(10'h00, 32'h0, 1'b0, "reset_ctrl");
    apb_read(10'h04, MAJF, 1'b0, "reset_status");
    apb_read(10'h08, 32'h0, 1'b0, "reset_chen");
    apb_read(10'h0C, 32'h1, 1'b0, "reset_settle");
    apb_read(10'h10, 32'h0, 1'b0, "reset_result");

    run_scan(2'b01, 3, 2'b01, "single_ch0");
    run_scan(2'b11, 2, 2'b10, "both_ch");
    run_scan(2'b00, 5, 2'b11, "none_en");
    run_scan(2'b10, 0, 2'b10, "settle0_ch1");
    for (int k = 0; k < 8; k++)
      run_scan(2'($urandom_range(0, 3)), $urandom_range(0, 6), 2'($urandom_range(0, 3)),
               $sformatf("rand%0d", k));

    // continuous mode, then abort while channel 1 is being driven in the second pass
    apb_write(10'h08, 32'h3);
    apb_write(10'h0C, 32'd20);
    in_drv = 2'b11;
    apb_write(10'h00, 32'h7);
    begin
      int n = 0;
      while (irq_out !== 1'b1 && n < 400) begin @(posedge clk_in); #1; n++; end
      check("cont_first_done", {31'd0, irq_out}, 32'd1);
    end
    wait_pin(1, "cont_second_pass_ch1");
    apb_write(10'h00, 32'h7);
    check("start_while_busy_ignored", {30'd0, drv_mask()}, 32'h2);
    apb_write(10'h00, 32'hF);
    check("abort_pins_released", {30'd0, drv_mask()}, 32'h0);
    check("abort_irq_kept", {31'd0, irq_out}, 32'd1);
    apb_read(10'h04, 32'h2 | MAJF, 1'b0, "abort_status");
    apb_read(10'h10, 32'h1, 1'b0, "abort_partial_result");
    hi_cnt[0] = 0; hi_cnt[1] = 0;
    repeat (30) @(posedge clk_in);
    check("abort_idle_no_drive", hi_cnt[0] + hi_cnt[1], 0);
    apb_read(10'h04, 32'h2 | MAJF, 1'b0, "abort_status_later");

    apb_read(10'h3C, 32'h0, 1'b1, "unmapped_read");
    apb_write(10'h10, 32'hFF);
    apb_read(10'h10, 32'h1, 1'b0, "result_ro");
    apb_read(10'h00, 32'h6, 1'b0, "ctrl_readback");
    apb_write(10'h00, 32'h0);

    // reset while driving
    apb_write(10'h04, 32'h2);
    apb_write(10'h08, 32'h1);
    apb_write(10'h00, 32'h5);
    wait_pin(0, "pre_reset_drive");
    #3 reset_int = 1'b0;
    #1;
    check("reset_mid_pins", {30'd0, drv_mask()}, 32'd0);
    check("reset_mid_irq", {31'd0, irq_out}, 32'd0);
    @(posedge clk_in); #2;
    reset_int = 1'b1;
    apb_read(10'h04, MAJF, 1'b0, "post_reset_status");
    apb_read(10'h10, 32'h0, 1'b0, "post_reset_result");
    apb_read(10'h0C, 32'h1, 1'b0, "post_reset_settle");

    repeat (2) @(posedge clk_in);
    check("scoreboard_drained", sbq.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end
endmodule
